// File: rtl/reset_seq_if.sv
// reset_seq_if: bundle of the PLL-lock, software-reset and watchdog inputs and
// the staged reset outputs of reset_seq.
//   master : drives pll_lock, sw_rst_req, wdt_en, wdt_kick, wdt_timeout and
//            observes rst_out, all_done, cause (PLL wrapper / system side)
//   slave  : the reset sequencer itself
interface reset_seq_if #(
  parameter int NUM_OUT = 4,
  parameter int WDT_W   = 16
);
  logic               pll_lock;
  logic               sw_rst_req;
  logic               wdt_en;
  logic               wdt_kick;
  logic [WDT_W-1:0]   wdt_timeout;
  logic [NUM_OUT-1:0] rst_out;
  logic               all_done;
  logic [1:0]         cause;

  modport master (
    output pll_lock, sw_rst_req, wdt_en, wdt_kick, wdt_timeout,
    input  rst_out, all_done, cause
  );

  modport slave (
    input  pll_lock, sw_rst_req, wdt_en, wdt_kick, wdt_timeout,
    output rst_out, all_done, cause
  );
endinterface

// File: rtl/reset_seq.sv
// reset_seq: staged reset generator sitting between the PLL and the system.
// Waits for a filtered, stable PLL lock, then a 2^CNT_W-cycle settle period,
// then releases NUM_OUT active-high resets one at a time, STAGE_GAP cycles
// apart (bit 0 first). Lock loss, a software request or a watchdog timeout
// throws every output back into reset together; the reason is kept in cause.
// Ports:
//   clk     : system clock (PLL output)
//   reset_n : asynchronous active-low power-on clear
//   bus     : reset_seq_if.slave -- pll_lock (async), sw_rst_req, wdt_en,
//             wdt_kick, wdt_timeout in; rst_out, all_done, cause out
module reset_seq #(
  parameter int NUM_OUT   = 4,
  parameter int CNT_W     = 8,
  parameter int LOCK_FILT = 4,
  parameter int STAGE_GAP = 16,
  parameter int WDT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  reset_seq_if.slave       bus
);

  localparam int FILT_W   = $clog2(LOCK_FILT + 1);
  localparam int GAP_W    = $clog2(STAGE_GAP + 1);
  localparam int STG_W    = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int LAST_STG = (NUM_OUT > 1) ? NUM_OUT - 2 : 0;

  localparam logic [1:0] CAUSE_POR  = 2'd0;
  localparam logic [1:0] CAUSE_LOCK = 2'd1;
  localparam logic [1:0] CAUSE_SW   = 2'd2;
  localparam logic [1:0] CAUSE_WDT  = 2'd3;

  typedef enum logic [1:0] {HOLD, WAIT, RELEASE, RUN} state_t;

  state_t             state_reg;
  logic               sync1_reg;
  logic               lock_s_reg;
  logic [FILT_W-1:0]  filt_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [STG_W-1:0]   stg_reg;
  logic [GAP_W-1:0]   gap_reg;
  logic [WDT_W-1:0]   wdt_reg;
  logic [NUM_OUT-1:0] rst_out_reg;
  logic               all_done_reg;
  logic [1:0]         cause_reg;

  logic               wdt_on;
  logic               wdt_trip;
  logic               reenter;
  logic [NUM_OUT-1:0] rst_shift;

  // A kick on the trip edge suppresses the trip.
  assign wdt_on    = bus.wdt_en && (bus.wdt_timeout != '0);
  assign wdt_trip  = (state_reg == RUN) && wdt_on && !bus.wdt_kick &&
                     (wdt_reg == bus.wdt_timeout - WDT_W'(1));
  assign reenter   = (state_reg != HOLD) &&
                     (!lock_s_reg || wdt_trip || bus.sw_rst_req);
  // Outputs release bit 0 first, so each stage is a left shift of the mask;
  // this keeps the vector monotonic (bits only ever fall while releasing).
  assign rst_shift = rst_out_reg << 1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= HOLD;
      sync1_reg    <= 1'b0;
      lock_s_reg   <= 1'b0;
      filt_reg     <= '0;
      cnt_reg      <= '0;
      stg_reg      <= '0;
      gap_reg      <= '0;
      wdt_reg      <= '0;
      rst_out_reg  <= '1;
      all_done_reg <= 1'b0;
      cause_reg    <= CAUSE_POR;
    end else begin
      sync1_reg  <= bus.pll_lock;
      lock_s_reg <= sync1_reg;

      if (reenter) begin
        state_reg    <= HOLD;
        rst_out_reg  <= '1;
        all_done_reg <= 1'b0;
        filt_reg     <= '0;
        cnt_reg      <= '0;
        stg_reg      <= '0;
        gap_reg      <= '0;
        wdt_reg      <= '0;
        // Priority: lock loss, then watchdog, then software request.
        if (!lock_s_reg)   cause_reg <= CAUSE_LOCK;
        else if (wdt_trip) cause_reg <= CAUSE_WDT;
        else               cause_reg <= CAUSE_SW;
      end else begin
        case (state_reg)
          HOLD: begin
            if (!lock_s_reg) begin
              filt_reg <= '0;
            end else if (filt_reg == FILT_W'(LOCK_FILT - 1)) begin
              state_reg <= WAIT;
              cnt_reg   <= '0;
              filt_reg  <= '0;
            end else begin
              filt_reg <= filt_reg + FILT_W'(1);
            end
          end
          WAIT: begin
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (cnt_reg == '1) begin
              rst_out_reg <= rst_shift;
              stg_reg     <= '0;
              gap_reg     <= '0;
              if (NUM_OUT == 1) begin
                state_reg    <= RUN;
                all_done_reg <= 1'b1;
              end else begin
                state_reg <= RELEASE;
              end
            end
          end
          RELEASE: begin
            if (gap_reg == GAP_W'(STAGE_GAP - 1)) begin
              gap_reg     <= '0;
              rst_out_reg <= rst_shift;
              stg_reg     <= stg_reg + STG_W'(1);
              // stg counts releases after bit 0; the last one ends the sequence
              if (stg_reg == STG_W'(LAST_STG)) begin
                state_reg    <= RUN;
                all_done_reg <= 1'b1;
              end
            end else begin
              gap_reg <= gap_reg + GAP_W'(1);
            end
          end
          RUN: begin
            if (!wdt_on || bus.wdt_kick) wdt_reg <= '0;
            else                         wdt_reg <= wdt_reg + WDT_W'(1);
          end
          default: state_reg <= HOLD;
        endcase
      end
    end
  end

  assign bus.rst_out  = rst_out_reg;
  assign bus.all_done = all_done_reg;
  assign bus.cause    = cause_reg;

endmodule

// File: tb/tb_reset_seq.sv
// tb_reset_seq: scoreboard bench for reset_seq. Stimulus pushes each expected
// output change {cycle, rst_out, all_done, cause} into a queue; a monitor on
// the falling edge pops and compares whenever the outputs change, and flags
// changes nobody expected and expected changes that never came.
module tb_reset_seq;
  localparam int NUM_OUT   = 4;
  localparam int CNT_W     = 8;
  localparam int LOCK_FILT = 4;
  localparam int STAGE_GAP = 16;
  localparam int WDT_W     = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  reset_seq_if #(.NUM_OUT(NUM_OUT), .WDT_W(WDT_W)) bus ();

  reset_seq #(
    .NUM_OUT(NUM_OUT), .CNT_W(CNT_W), .LOCK_FILT(LOCK_FILT),
    .STAGE_GAP(STAGE_GAP), .WDT_W(WDT_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  typedef struct {
    int unsigned cyc;
    logic [6:0]  val;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [6:0]  prev = {4'hF, 1'b0, 2'd0};
  logic [6:0]  cur;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic ev(input string name, input int unsigned at, input logic [3:0] r,
                    input logic ad, input logic [1:0] c);
    exp_t x;
    x.cyc = at; x.val = {r, ad, c}; x.name = name;
    exp_q.push_back(x);
    $display("expect %-14s cycle %0d rst_out=%h all_done=%0d cause=%0d", name, at, r, ad, c);
  endtask

  // Advance to just after rising edge c; inputs set here are first sampled at c+1.
  task automatic step_to(input int unsigned c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic kick_at(input int unsigned edge_no);
    step_to(edge_no - 1);
    bus.wdt_kick = 1'b1;
    step_to(edge_no);
    bus.wdt_kick = 1'b0;
  endtask

  // Full release sequence expected after HOLD entry / stable lock at base.
  task automatic ev_seq(input string tag, input int unsigned b, input logic [1:0] c);
    ev({tag, " rst0"}, b,                 4'hE, 1'b0, c);
    ev({tag, " rst1"}, b + STAGE_GAP,     4'hC, 1'b0, c);
    ev({tag, " rst2"}, b + 2 * STAGE_GAP, 4'h8, 1'b0, c);
    ev({tag, " run"},  b + 3 * STAGE_GAP, 4'h0, 1'b1, c);
  endtask

  // Monitor
  always @(negedge clk) begin
    cur = {bus.rst_out, bus.all_done, bus.cause};
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      check({e.name, " missed"}, cyc, e.cyc);
    end
    if (cur !== prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected change", {25'd0, cur}, {25'd0, prev});
      end else begin
        e = exp_q.pop_front();
        check({e.name, " cycle"}, e.cyc == cyc ? e.cyc : cyc, e.cyc);
        check({e.name, " value"}, {25'd0, cur}, {25'd0, e.val});
        $display("seen   %-14s cycle %0d rst_out=%h all_done=%0d cause=%0d",
                 e.name, cyc, cur[6:3], cur[2], cur[1:0]);
      end
      prev = cur;
    end
  end

  int unsigned b, t0, r, s, d, u, w, k, h, p;

  initial begin
    bus.pll_lock    = 1'b1;
    bus.sw_rst_req  = 1'b0;
    bus.wdt_en      = 1'b0;
    bus.wdt_kick    = 1'b0;
    bus.wdt_timeout = '0;

    // Power-on with lock already high
    #1 reset_n = 1'b0;
    #1;
    check("reset rst_out", {28'd0, bus.rst_out}, 32'hF);
    check("reset all_done", {31'd0, bus.all_done}, 32'd0);
    check("reset cause", {30'd0, bus.cause}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    b = cyc;
    ev_seq("poweron", b + 262, 2'd0);
    step_to(b + 320);

    // Lock loss in RUN, then chatter with 3-cycle high runs, then stable
    t0 = cyc;
    bus.pll_lock = 1'b0;
    ev("lockloss run", t0 + 3, 4'hF, 1'b0, 2'd1);
    step_to(t0 + 6);
    repeat (3) begin
      bus.pll_lock = 1'b1;
      step_to(cyc + 3);
      bus.pll_lock = 1'b0;
      step_to(cyc + 2);
    end
    bus.pll_lock = 1'b1;
    r = cyc;
    ev_seq("chatter", r + 262, 2'd1);
    step_to(r + 320);

    // Software reset in RUN, then lock drop during RELEASE
    s = cyc;
    bus.sw_rst_req = 1'b1;
    ev("sw hold", s + 1, 4'hF, 1'b0, 2'd2);
    ev("sw rst0", s + 261, 4'hE, 1'b0, 2'd2);
    step_to(s + 1);
    bus.sw_rst_req = 1'b0;
    step_to(s + 268);
    bus.pll_lock = 1'b0;
    d = cyc;
    ev("rel lockloss", d + 3, 4'hF, 1'b0, 2'd1);
    step_to(d + 10);
    bus.pll_lock = 1'b1;
    u = cyc;
    ev_seq("relock", u + 262, 2'd1);
    step_to(u + 320);

    // Watchdog: kicks every 99, one kick on the trip edge, then starve it
    w = cyc;
    bus.wdt_en = 1'b1;
    bus.wdt_timeout = 16'd100;
    k = w + 99;
    kick_at(k);
    k = k + 99; kick_at(k);
    k = k + 99; kick_at(k);
    k = k + 100; kick_at(k);
    h = k + 100;
    ev("wdt trip", h, 4'hF, 1'b0, 2'd3);
    step_to(h + 10);
    bus.wdt_timeout = '0;
    ev_seq("after wdt", h + 260, 2'd3);
    step_to(h + 620);

    // Software request and watchdog trip on the same edge: watchdog wins
    p = cyc;
    bus.wdt_timeout = 16'd100;
    step_to(p + 99);
    bus.sw_rst_req = 1'b1;
    ev("sw+wdt", p + 100, 4'hF, 1'b0, 2'd3);
    step_to(p + 100);
    bus.sw_rst_req = 1'b0;
    h = p + 100;
    ev_seq("after sw+wdt", h + 260, 2'd3);

    // Lock drop, trip and software request all on edge h+408: lock wins
    step_to(h + 405);
    bus.pll_lock = 1'b0;
    step_to(h + 407);
    bus.sw_rst_req = 1'b1;
    ev("all three", h + 408, 4'hF, 1'b0, 2'd1);
    step_to(h + 408);
    bus.sw_rst_req = 1'b0;
    step_to(h + 430);

    check("scoreboard drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/reset_seq.md
Name: reset_seq

Overview:
- Parametrised successor to the single-output PLL-lock reset generator used in the top levels.
- Produces NUM_OUT active-high reset outputs that are released in a staged order after the PLL lock has been stable for a filtered period.
- Re-enters reset on any of three events: lock loss, a software reset request, or a watchdog timeout. Records which event caused the last reset.
- Sits in each top level between the PLL and the system core and its peripherals.

Parameters:
- NUM_OUT, 4: number of reset outputs; stage k drives rst_out[k].
- CNT_W, 8: width of the post-lock wait counter; the wait lasts 2^CNT_W cycles.
- LOCK_FILT, 4: consecutive synced-high lock cycles required before waiting starts (>=1).
- STAGE_GAP, 16: cycles between successive stage releases (>=1).
- WDT_W, 16: width of the watchdog counter and of wdt_timeout.

Ports:
- clk, input, 1: system clock (PLL output).
- reset_n, input, 1: asynchronous active-low reset. Power-on clear; all state goes to reset values.
- pll_lock, input, 1: PLL lock, asynchronous to clk. Passes through a 2-flop synchroniser; the output is lock_s.
- sw_rst_req, input, 1: software reset request, single-cycle pulse.
- wdt_en, input, 1: watchdog enable.
- wdt_kick, input, 1: watchdog service pulse.
- wdt_timeout, input, WDT_W: watchdog limit; 0 disables the watchdog.
- rst_out, output, NUM_OUT: active-high resets. Bit 0 is released first.
- all_done, output, 1: high while in RUN (all resets released).
- cause, output, 2: last reset cause. 0 = power-on, 1 = lock loss, 2 = software, 3 = watchdog.

Behaviour:
- reset_n low (asynchronous) forces these values:
  - state = HOLD
  - rst_out = all ones
  - all_done = 0
  - cause = 0
  - lock synchroniser, filter count, wait count, stage count and watchdog count = 0
- States: HOLD, WAIT, RELEASE, RUN.
- HOLD:
  - rst_out is all ones.
  - filt increments on each edge where lock_s = 1 and clears when lock_s = 0.
  - When filt == LOCK_FILT-1 and lock_s = 1, go to WAIT with cnt = 0.
- WAIT:
  - cnt increments every edge.
  - When cnt == 2^CNT_W-1, go to RELEASE. On the same edge, clear rst_out[0] and set stg = 0 and gap = 0.
- RELEASE:
  - gap increments every edge.
  - When gap == STAGE_GAP-1: clear rst_out[stg+1], increment stg, and set gap = 0.
  - When the last bit clears, go to RUN on the same edge and set all_done = 1.
  - With NUM_OUT = 1, WAIT goes directly to RUN on that edge.
- Release timing with lock high from reset_n release (edges counted from the first edge after reset_n deasserts):
  - rst_out[0] falls at edge 2 + LOCK_FILT + 2^CNT_W (262 with defaults).
  - rst_out[k] falls STAGE_GAP*k edges later; rst_out[3] at edge 310.
- RUN watchdog (active only when wdt_en = 1 and wdt_timeout != 0):
  - wdt counts up each edge.
  - wdt_kick clears it to 0.
  - If wdt == wdt_timeout-1 without a kick, trip.
  - Kick and trip on the same edge: the kick wins.
  - The wdt count is held at 0 outside RUN or while the watchdog is disabled.
- Re-entry to HOLD, checked every edge in WAIT, RELEASE and RUN, in priority order (highest first):
  1. lock_s = 0: cause = 1.
  2. Watchdog trip (RUN only): cause = 3.
  3. sw_rst_req = 1: cause = 2.
- On re-entry to HOLD, on the same edge:
  - rst_out = all ones, all_done = 0.
  - filt, cnt, stg, gap and wdt cleared.
- sw_rst_req and wdt_kick are ignored in HOLD.
- cause is sticky; it changes only on a re-entry to HOLD or on reset_n.
- Lock chatter in HOLD restarts the filter. The wait only begins after LOCK_FILT consecutive high cycles.
- After a software or watchdog reset with lock still high: the synchroniser is already settled, so rst_out[0] falls LOCK_FILT + 2^CNT_W edges after HOLD entry.
- rst_out is registered and glitch-free. Bits never re-assert individually; all re-assert together.

Test Plan:
- Power-on: reset_n low for 3 cycles, pll_lock held high.
  -> rst_out = 4'hF until edge 262. Bits fall at edges 262, 278, 294 and 310.
  -> all_done rises at edge 310; cause = 0.
- Lock chatter: pll_lock toggles with high runs of 3 cycles, then stays high.
  -> Stays in HOLD and rst_out = 4'hF throughout the chatter.
  -> Release occurs 2 + 4 + 256 edges after the final stable rise.
- Lock loss mid-RELEASE: drop pll_lock at edge 285.
  -> rst_out = 4'hF 2 edges after the synchroniser sees the drop; all_done = 0; cause = 1.
  -> Re-raise lock: the full sequence repeats.
- Software reset in RUN: pulse sw_rst_req.
  -> Next edge: rst_out = 4'hF and cause = 2.
  -> rst_out[0] falls 260 edges later.
- Watchdog: wdt_en = 1, wdt_timeout = 100.
  -> Kicking every 99 cycles: never trips.
  -> Stop kicking: trips 100 edges after the last kick; cause = 3.
  -> wdt_timeout = 0: never trips.
- Priority: sw_rst_req, a watchdog trip and a lock drop on the same edge -> cause = 1.
  - Kick coincident with the trip edge -> no reset.
